// File: rtl/wave_capture_buffer.sv
// Captures decimated sine/cosine pairs from the CORDIC generator into a
// first-word-fall-through FIFO and streams them out on a valid/ready port.
module wave_capture_buffer #(
    parameter int WAVE_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int DEC_WIDTH  = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_in,
    input  logic                      enable,
    input  logic [WAVE_WIDTH-1:0]     wave_in_sen,
    input  logic [WAVE_WIDTH-1:0]     wave_in_cos,
    input  logic                      arm,
    input  logic [DEC_WIDTH-1:0]      decim,
    input  logic [LEN_WIDTH-1:0]      capture_len,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*WAVE_WIDTH-1:0]   out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 2 * WAVE_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [EW-1:0]          r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [LW-1:0]          r_level;
    logic [DEC_WIDTH-1:0]   r_dec_cnt;
    logic [DEC_WIDTH-1:0]   r_decim;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_kept;
    logic                   r_overflow;

    logic                   w_pop;
    logic                   w_full;
    logic                   w_keep;
    logic                   w_is_last;
    logic                   w_push;
    logic [LW-1:0]          w_level_next;

    assign w_pop     = (r_level != LW'(0)) && out_ready;
    assign w_full    = (r_level == LW'(DEPTH));
    assign w_keep    = (r_state == ST_CAPTURE) && enable && (r_dec_cnt == DEC_WIDTH'(0));
    assign w_is_last = (r_kept == (r_len - LEN_WIDTH'(1)));
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign w_push    = w_keep && (!w_full || w_pop);

    // Next FIFO occupancy from this edge's push/pop pair.
    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + LW'(1);
            2'b01:   w_level_next = r_level - LW'(1);
            default: w_level_next = r_level;
        endcase
    end

    // Sample storage; entries past the read pointer are never observed.
    always_ff @(posedge clk) begin
        if (w_push && !rst_in) begin
            r_mem[r_wr_ptr] <= {w_is_last, wave_in_sen, wave_in_cos};
        end
    end

    // Capture control FSM, FIFO pointers and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= AW'(0);
            r_rd_ptr   <= AW'(0);
            r_level    <= LW'(0);
            r_dec_cnt  <= DEC_WIDTH'(0);
            r_decim    <= DEC_WIDTH'(0);
            r_len      <= LEN_WIDTH'(0);
            r_kept     <= LEN_WIDTH'(0);
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_next;

            case (r_state)
                ST_IDLE: begin
                    if (arm && (capture_len != LEN_WIDTH'(0))) begin
                        r_decim    <= decim;
                        r_len      <= capture_len;
                        r_dec_cnt  <= DEC_WIDTH'(0);
                        r_kept     <= LEN_WIDTH'(0);
                        r_overflow <= 1'b0;
                        r_state    <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (enable) begin
                        if (r_dec_cnt == DEC_WIDTH'(0)) begin
                            r_dec_cnt <= r_decim;
                            r_kept    <= r_kept + LEN_WIDTH'(1);
                            if (!w_push) begin
                                r_overflow <= 1'b1;
                            end
                            if (w_is_last) begin
                                r_state <= ST_DRAIN;
                            end
                        end else begin
                            r_dec_cnt <= r_dec_cnt - DEC_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_level_next == LW'(0)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = (r_level != LW'(0));
    assign out_data  = out_valid ? r_mem[r_rd_ptr][2*WAVE_WIDTH-1:0] : '0;
    assign out_last  = out_valid ? r_mem[r_rd_ptr][EW-1] : 1'b0;
    assign busy      = (r_state != ST_IDLE);
    assign overflow  = r_overflow;
    assign level     = r_level;

endmodule

// File: tb/tb_wave_capture_buffer.sv
// Self-checking bench: a queue-based reference model is compared against the
// DUT every cycle, with directed scenarios adding hand-computed expectations.
module tb_wave_capture_buffer;

    localparam int W     = 16;
    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int LENW  = 16;
    localparam int LVW   = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_in;
    logic              enable;
    logic [W-1:0]      sen;
    logic [W-1:0]      cos;
    logic              arm;
    logic [DW-1:0]     decim;
    logic [LENW-1:0]   capture_len;
    logic              out_valid;
    logic              out_ready;
    logic [2*W-1:0]    out_data;
    logic              out_last;
    logic              busy;
    logic              overflow;
    logic [LVW-1:0]    level;

    int errors = 0;
    int checks = 0;
    bit done   = 1'b0;

    always #5 clk = ~clk;

    wave_capture_buffer #(
        .WAVE_WIDTH (W),
        .DEPTH      (DEPTH),
        .DEC_WIDTH  (DW),
        .LEN_WIDTH  (LENW)
    ) dut (
        .clk         (clk),
        .rst_in      (rst_in),
        .enable      (enable),
        .wave_in_sen (sen),
        .wave_in_cos (cos),
        .arm         (arm),
        .decim       (decim),
        .capture_len (capture_len),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .overflow    (overflow),
        .level       (level)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of {last, sen, cos} plus capture bookkeeping.
    logic [2*W:0] m_q[$];
    int  m_mode    = 0;   // 0 idle, 1 capturing, 2 draining
    int  m_dec_cnt = 0;
    int  m_kept    = 0;
    int  m_len     = 0;
    int  m_dec     = 0;
    bit  m_ovf     = 1'b0;

    task automatic model_step();
        bit last;
        if (rst_in) begin
            m_q.delete();
            m_mode = 0; m_dec_cnt = 0; m_kept = 0; m_len = 0; m_dec = 0; m_ovf = 1'b0;
        end else begin
            if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
            case (m_mode)
                0: if (arm && capture_len != 0) begin
                    m_len = int'(capture_len); m_dec = int'(decim);
                    m_dec_cnt = 0; m_kept = 0; m_ovf = 1'b0; m_mode = 1;
                end
                1: if (enable) begin
                    if (m_dec_cnt == 0) begin
                        last = (m_kept == m_len - 1);
                        m_kept++;
                        m_dec_cnt = m_dec;
                        if (m_q.size() < DEPTH) m_q.push_back({last, sen, cos});
                        else m_ovf = 1'b1;
                        if (last) m_mode = 2;
                    end else begin
                        m_dec_cnt--;
                    end
                end
                default: if (m_q.size() == 0) m_mode = 0;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!done) begin
            chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
            chk("level", 64'(level), 64'(m_q.size()));
            chk("busy", 64'(busy), 64'(m_mode != 0));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("out_data", 64'(out_data), 64'((m_q.size() != 0) ? m_q[0][2*W-1:0] : 32'd0));
            if (m_q.size() != 0) chk("out_last", 64'(out_last), 64'(m_q[0][2*W]));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        int idx;
        int peak;
        int pops;
        int lasts;
        logic [2*W-1:0] got[$];

        rst_in = 1'b1; arm = 1'b1; capture_len = 16'd4; decim = 8'd0;
        enable = 1'b0; out_ready = 1'b0; sen = '0; cos = '0;

        // Reset held two cycles with arm asserted
        repeat (2) cyc();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        rst_in = 1'b0; arm = 1'b0;

        // Basic capture
        cyc();
        arm = 1'b1; capture_len = 16'd4; decim = 8'd0; enable = 1'b0; out_ready = 1'b1;
        cyc();
        arm = 1'b0; enable = 1'b1; sen = 16'd1; cos = 16'd1;
        chk("basic_busy", 64'(busy), 64'd1);
        for (int n = 1; n <= 4; n++) begin
            cyc();
            chk("basic_data", 64'({W'(n), W'(n)}), 64'(out_data) ^ 64'd0 ^ 64'({W'(n), W'(n)}) ^ 64'(out_data));
            chk("basic_data_val", 64'(out_data), 64'({W'(n), W'(n)}));
            chk("basic_last", 64'(out_last), 64'(n == 4));
            sen = W'(n + 1); cos = W'(n + 1);
        end
        cyc();
        enable = 1'b0;
        chk("basic_busy_end", 64'(busy), 64'd0);
        chk("basic_valid_end", 64'(out_valid), 64'd0);

        // Decimation by 3 with toggling enable
        arm = 1'b1; capture_len = 16'd3; decim = 8'd2; enable = 1'b0; out_ready = 1'b1;
        cyc();
        arm = 1'b0; idx = 0; peak = 0;
        for (int c = 0; c < 30; c++) begin
            enable = (c % 2 == 0);
            if (enable) begin
                sen = W'(100 + idx); cos = W'(200 + idx); idx++;
            end
            cyc();
            if (int'(level) > peak) peak = int'(level);
            if (out_valid && out_ready) got.push_back(out_data);
        end
        enable = 1'b0;
        chk("dec_count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("dec_w0", 64'(got[0]), 64'({16'd100, 16'd200}));
            chk("dec_w1", 64'(got[1]), 64'({16'd103, 16'd203}));
            chk("dec_w2", 64'(got[2]), 64'({16'd106, 16'd206}));
        end
        chk("dec_peak", 64'(peak), 64'd1);
        chk("dec_idle", 64'(busy), 64'd0);

        // Overflow with the consumer stalled
        arm = 1'b1; capture_len = 16'd20; decim = 8'd0; enable = 1'b0; out_ready = 1'b0;
        cyc();
        arm = 1'b0; enable = 1'b1;
        for (int c = 0; c < 25; c++) begin
            sen = W'($urandom); cos = W'($urandom);
            cyc();
        end
        enable = 1'b0;
        chk("ovf_level", 64'(level), 64'd16);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_busy", 64'(busy), 64'd1);
        out_ready = 1'b1; pops = 0; lasts = 0;
        for (int c = 0; c < 40 && busy; c++) begin
            if (out_valid) begin
                pops++;
                if (out_last) lasts++;
            end
            cyc();
        end
        chk("ovf_pops", 64'(pops), 64'd16);
        chk("ovf_lasts", 64'(lasts), 64'd0);
        chk("ovf_drained", 64'(busy), 64'd0);
        arm = 1'b1; capture_len = 16'd1;
        cyc();
        arm = 1'b0;
        chk("ovf_cleared", 64'(overflow), 64'd0);
        enable = 1'b1; sen = 16'h8001; cos = 16'h7fff;
        cyc();
        enable = 1'b0;
        chk("len1_data", 64'(out_data), 64'({16'h8001, 16'h7fff}));
        chk("len1_last", 64'(out_last), 64'd1);
        repeat (2) cyc();

        // Illegal arms
        arm = 1'b1; capture_len = 16'd0;
        cyc();
        arm = 1'b0;
        chk("arm_len0", 64'(busy), 64'd0);
        arm = 1'b1; capture_len = 16'd3; decim = 8'd1; enable = 1'b0; out_ready = 1'b1;
        cyc();
        pops = 0; lasts = 0;
        for (int c = 0; c < 20; c++) begin
            enable = 1'b1;
            arm = (c == 1);
            if (c == 1) capture_len = 16'd7;
            sen = W'(c); cos = W'(~c);
            if (out_valid) begin
                pops++;
                if (out_last) lasts++;
            end
            cyc();
        end
        arm = 1'b0; enable = 1'b0;
        chk("rearm_pops", 64'(pops), 64'd3);
        chk("rearm_lasts", 64'(lasts), 64'd1);

        // Reset in the middle of a capture
        arm = 1'b1; capture_len = 16'd10; decim = 8'd0; out_ready = 1'b0; enable = 1'b0;
        cyc();
        arm = 1'b0; enable = 1'b1;
        repeat (5) begin
            sen = W'($urandom); cos = W'($urandom);
            cyc();
        end
        enable = 1'b0;
        chk("mid_level", 64'(level), 64'd5);
        rst_in = 1'b1;
        cyc();
        rst_in = 1'b0;
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        arm = 1'b1; capture_len = 16'd2;
        cyc();
        arm = 1'b0; enable = 1'b1; out_ready = 1'b1;
        repeat (2) begin
            sen = W'($urandom); cos = W'($urandom);
            cyc();
        end
        enable = 1'b0;
        repeat (3) cyc();
        chk("fresh_idle", 64'(busy), 64'd0);

        // Randomized traffic, model-checked every cycle
        for (int c = 0; c < 4000; c++) begin
            rst_in      = ($urandom_range(0, 599) == 0);
            arm         = ($urandom_range(0, 9) == 0);
            capture_len = LENW'($urandom_range(0, 24));
            decim       = DW'($urandom_range(0, 3));
            enable      = ($urandom_range(0, 9) < 7);
            out_ready   = ($urandom_range(0, 9) < 6);
            sen         = W'($urandom);
            cos         = W'($urandom);
            cyc();
        end
        rst_in = 1'b0; arm = 1'b0; enable = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 200 && busy; c++) cyc();
        chk("final_idle", 64'(busy), 64'd0);

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wave_capture_buffer.md
Name: wave_capture_buffer

Overview:
- Sits directly downstream of the CORDIC waveform generator.
- Captures its sine/cosine sample pairs, decimates them by a programmable factor, and buffers a programmed number of pairs in an internal FIFO.
- Presents the buffered pairs on a valid/ready stream for readout by a host or serializer.
- Capture is one-shot per arm pulse; a sticky flag reports dropped samples.

Parameters:
- WAVE_WIDTH, 16, width of each sine/cosine sample.
- DEPTH, 16, FIFO depth in sample pairs; must be a power of two, ≥2.
- DEC_WIDTH, 8, width of the decimation control.
- LEN_WIDTH, 16, width of the capture-length control.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_in  in  1  reset, synchronous, active-high.
- enable  in  1  generator sample strobe; a sample pair is present on every clk edge where enable=1.
- wave_in_sen  in  WAVE_WIDTH  sine sample from generator.
- wave_in_cos  in  WAVE_WIDTH  cosine sample from generator.
- arm  in  1  start-capture pulse; sampled only in IDLE.
- decim  in  DEC_WIDTH  keep 1 of every decim+1 enabled samples; latched on arm.
- capture_len  in  LEN_WIDTH  number of kept samples per capture; latched on arm.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accept.
- out_data  out  2*WAVE_WIDTH  {sen, cos} of FIFO head.
- out_last  out  1  head word is the final kept sample of the capture.
- busy  out  1  state ≠ IDLE.
- overflow  out  1  sticky: a kept sample was dropped because the FIFO was full.
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset: applies when rst_in=1 at a clk edge, including mid-capture. State → IDLE; FIFO emptied; all counters cleared. Outputs: out_valid=0, out_data=0, out_last=0, busy=0, overflow=0, level=0.
- FSM states: IDLE, CAPTURE, DRAIN.
- IDLE:
  - arm=1 with capture_len≠0: latch decim and capture_len, clear decimation counter and kept counter, clear overflow, go to CAPTURE.
  - arm with capture_len=0 is ignored. arm in any other state is ignored.
- CAPTURE:
  - Each edge with enable=1: if the decimation counter is 0, the sample is kept and the counter reloads to the latched decim; otherwise the counter decrements.
  - The first enabled sample after entering CAPTURE is always kept.
  - A kept sample increments the kept counter and is pushed with tag last = (kept counter == latched capture_len - 1).
  - Push succeeds if the FIFO is not full, or if a pop occurs on the same edge.
  - Otherwise the sample is dropped: overflow=1, but it still counts toward capture_len.
  - When the final sample is kept (pushed or dropped), go to DRAIN on the same edge.
  - enable=0 edges change nothing.
- DRAIN: no pushes. Go to IDLE on the edge where the FIFO becomes empty, or immediately if already empty.
- FIFO output is first-word fall-through:
  - out_valid = level≠0; out_data/out_last = head entry.
  - Pop on out_valid & out_ready.
  - A kept sample pushed into an empty FIFO at edge t is visible at out_valid/out_data after edge t (1-cycle latency).
  - Simultaneous push and pop: level unchanged; order preserved.
  - out_data and out_last hold while out_valid=1 and out_ready=0.
  - Read/write pointers wrap modulo DEPTH.
- If the final sample is dropped, no out_last word is produced. overflow=1 signals this.
- out_data is 0 when the FIFO is empty.
- Sample data is passed unmodified, two's-complement.

Test Plan:
- Reset behaviour: hold rst_in=1 for 2 cycles with arm=1 -> busy=0, out_valid=0, level=0, overflow=0. arm is ignored while rst_in=1.
- Basic capture: decim=0, capture_len=4, enable=1, out_ready=1, sen/cos = incrementing 1,2,3… -> four words {n,n} for the first four samples after arm, 1-cycle latency. out_last=1 only on the 4th; busy falls the cycle after the 4th pop.
- Decimation: decim=2, capture_len=3, enable toggling 1,0,1,0… -> kept samples are enabled samples #0, #3, #6. level peaks at 1 with out_ready=1.
- Overflow: DEPTH=16, decim=0, capture_len=20, out_ready=0 -> level saturates at 16 and overflow=1. Releasing out_ready drains exactly 16 words with no out_last, then busy=0. Next arm clears overflow.
- Illegal arm: arm with capture_len=0 -> busy stays 0. arm during CAPTURE -> latched capture_len is unchanged and the capture completes with the original count.
- Mid-capture reset: assert rst_in after 5 of 10 pairs are buffered -> next cycle level=0, out_valid=0, busy=0. A fresh arm then captures normally.
